dump_sequencer: RTL and testbench
=================================

DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, sample depth of each channel RAM (12288 on DE-0).
REQ-002 SHALL have parameter LOG2, default 9, address width; 2^LOG2 >= ENTRIES.
REQ-003 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  one-cycle dump request from command logic.
REQ-006 SHALL have abort  input  1  cancel dump in progress.
REQ-007 SHALL have ch_sel  input  3  channel to dump; 1..5 valid.
REQ-008 SHALL have waddr  input  LOG2  capture write pointer; addresses the oldest sample.
REQ-009 SHALL have rdataCH1..rdataCH5  input  8 each  channel RAM read data.
REQ-010 SHALL have resp_sent  input  1  UART transmitter finished current byte.
REQ-011 SHALL have raddr  output  LOG2  read address to all channel RAMs.
REQ-012 SHALL have resp  output  8  byte to host.
REQ-013 SHALL have send_resp  output  1  one-cycle transmit request.
REQ-014 SHALL have busy  output  1  high in every state except IDLE.
REQ-015 SHALL have done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 RAM read latency SHALL be 1 cycle: rdataCHx in cycle k+1 reflects raddr in cycle k.
REQ-017 States SHALL be IDLE, RD1, RD2, WAIT, NAK_WAIT.
REQ-018 IDLE + start + ch_sel in 1..5: latch ch_sel, raddr <= waddr, count <= 0, go to RD1.
REQ-019 IDLE + start + ch_sel in {0,6,7}: resp <= 8'hEE, pulse send_resp, go to NAK_WAIT; RAMs not read.
REQ-020 RD1 SHALL hold raddr for one cycle, then go to RD2.
REQ-021 Leaving RD2: resp <= rdata of latched channel, send_resp high for exactly the next cycle, go to WAIT.
REQ-022 Latency: start sampled at edge 0 -> send_resp high in cycle 3.
REQ-023 WAIT + resp_sent with count < ENTRIES-1: count++, raddr++ wrapping ENTRIES-1 -> 0 (never ENTRIES..2^LOG2-1), go to RD1.
REQ-024 WAIT + resp_sent with count == ENTRIES-1: done pulse next cycle, go to IDLE.
REQ-025 NAK_WAIT + resp_sent: go to IDLE; done SHALL NOT pulse.
REQ-026 resp_sent SHALL be honoured in the same cycle send_resp is high; ignored outside WAIT/NAK_WAIT.
REQ-027 Exactly ENTRIES bytes per valid dump, in address order waddr, waddr+1, ... mod ENTRIES.
REQ-028 start while busy SHALL be ignored; ch_sel and waddr changes after acceptance SHALL have no effect.
REQ-029 abort in any non-IDLE state: IDLE next cycle, send_resp low, no done; abort wins over a simultaneous resp_sent; abort in IDLE wins over start.
REQ-030 resp SHALL hold its value until the next load.
REQ-031 count SHALL be LOG2 bits wide, compared to ENTRIES-1 with no overflow.

Reset
REQ-032 rst high at a clock edge: state IDLE, raddr 0, resp 0, send_resp 0, busy 0, done 0, count 0; takes precedence over all inputs, including mid-dump.

Verification
REQ-033 ch_sel=3, waddr=0, rdataCH3=raddr[7:0], resp_sent 2 cycles after each send_resp -> 384 bytes 00..FF,00..7F, then one done pulse.
REQ-034 ch_sel=1, waddr=383 -> raddr sequence 383,0,1,...,382; send_resp count 384; raddr never exceeds 383.
REQ-035 ch_sel=6 -> single resp=8'hEE with send_resp, no raddr change, no done, IDLE after resp_sent.
REQ-036 start at edge 0 -> send_resp in cycle 3; resp_sent held with send_resp -> next send_resp 3 cycles later.
REQ-037 abort after byte 10, and separately rst after byte 10 -> busy low next cycle, no done, no further send_resp; new start gives a full 384-byte dump.
REQ-038 start pulsed while busy, and ch_sel changed to 5 mid-dump -> ignored; bytes continue from the originally latched channel.

Source files
------------

// File: rtl/dump_sequencer.sv
// dump_sequencer: streams ENTRIES samples of one capture channel to the host, one byte per UART handshake.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - dump request / cancel
//   ch_sel              - channel to dump (1..5 valid, others answered with 8'hEE)
//   waddr               - capture write pointer, addresses the oldest sample
//   rdataCH1..rdataCH5  - channel RAM read data (1-cycle latency from raddr)
//   resp_sent           - transmitter finished current byte
//   raddr               - read address shared by all channel RAMs
//   resp, send_resp     - byte to host and its one-cycle transmit request
//   busy, done          - not idle / one-cycle completion pulse
module dump_sequencer #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      ch_sel,
    input  logic [LOG2-1:0] waddr,
    input  logic [7:0]      rdataCH1,
    input  logic [7:0]      rdataCH2,
    input  logic [7:0]      rdataCH3,
    input  logic [7:0]      rdataCH4,
    input  logic [7:0]      rdataCH5,
    input  logic            resp_sent,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      resp,
    output logic            send_resp,
    output logic            busy,
    output logic            done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD1      = 3'd1;
    localparam logic [2:0] RD2      = 3'd2;
    localparam logic [2:0] WAIT     = 3'd3;
    localparam logic [2:0] NAK_WAIT = 3'd4;
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    logic [2:0]      state;
    logic [2:0]      ch;
    logic [LOG2-1:0] count;
    logic [7:0]      rdata;
    logic            ch_ok;

    always_comb ch_ok = (ch_sel >= 3'd1) && (ch_sel <= 3'd5);

    // ch is latched at acceptance so later ch_sel changes cannot redirect the dump
    always_comb rdata = (ch == 3'd1) ? rdataCH1 :
                        (ch == 3'd2) ? rdataCH2 :
                        (ch == 3'd3) ? rdataCH3 :
                        (ch == 3'd4) ? rdataCH4 : rdataCH5;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= 3'd0;
            count     <= '0;
            raddr     <= '0;
            resp      <= 8'h00;
            send_resp <= 1'b0;
            done      <= 1'b0;
        end else begin
            send_resp <= 1'b0;
            done      <= 1'b0;
            // abort also covers IDLE, where it suppresses a simultaneous start
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (ch_ok) begin
                            ch    <= ch_sel;
                            raddr <= waddr;
                            count <= '0;
                            state <= RD1;
                        end else begin
                            resp      <= 8'hEE;
                            send_resp <= 1'b1;
                            state     <= NAK_WAIT;
                        end
                    end
                    RD1: state <= RD2;
                    RD2: begin
                        resp      <= rdata;
                        send_resp <= 1'b1;
                        state     <= WAIT;
                    end
                    WAIT: if (resp_sent) begin
                        if (count == LAST) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            count <= count + 1'b1;
                            raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
                            state <= RD1;
                        end
                    end
                    NAK_WAIT: if (resp_sent) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: directed scoreboard bench for dump_sequencer.
module tb_dump_sequencer;
    localparam int N = 384;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       resp_sent = 1'b0;
    logic [2:0] ch_sel;
    logic [8:0] waddr;
    logic [7:0] rd1, rd2, rd3, rd4, rd5;
    logic [8:0] raddr;
    logic [7:0] resp;
    logic       send_resp, busy, done;

    typedef struct {
        logic [7:0] d;
        logic [8:0] a;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_sent = 0;
    int         n_done = 0;
    int         ack_dly = 0;
    int         pend = 0;
    int         s0, d0;
    logic [8:0] max_a = '0;
    logic [8:0] ra;

    dump_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_sel(ch_sel), .waddr(waddr),
        .rdataCH1(rd1), .rdataCH2(rd2), .rdataCH3(rd3), .rdataCH4(rd4), .rdataCH5(rd5),
        .resp_sent(resp_sent), .raddr(raddr), .resp(resp), .send_resp(send_resp),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f(int c, logic [8:0] a);
        return (c == 3) ? a[7:0] : a[7:0] ^ 8'(c * 37);
    endfunction

    always @(posedge clk) begin
        rd1 <= f(1, raddr);
        rd2 <= f(2, raddr);
        rd3 <= f(3, raddr);
        rd4 <= f(4, raddr);
        rd5 <= f(5, raddr);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // monitor + UART responder, sampling on the falling edge
    always @(negedge clk) begin
        resp_sent = 1'b0;
        if (raddr > max_a) max_a = raddr;
        if (done) n_done++;
        if (send_resp) begin
            n_sent++;
            check("send_resp_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("resp", resp, e.d);
                check("raddr", raddr, e.a);
            end
            if (ack_dly == 0) resp_sent = 1'b1;
            else pend = ack_dly;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) resp_sent = 1'b1;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go(int c, int w);
        if (c >= 1 && c <= 5)
            for (int i = 0; i < N; i++) q.push_back('{f(c, 9'((w + i) % N)), 9'((w + i) % N)});
        ch_sel = 3'(c);
        waddr  = 9'(w);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle(int max);
        int k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        check("dump_finished_in_budget", busy, 0);
    endtask

    task automatic wait_bytes(int n);
        int k = 0;
        while (n_sent - s0 < n && k < 400) begin
            tick();
            k++;
        end
        check("bytes_reached", n_sent - s0, n);
    endtask

    task automatic full_dump(int c, int w, int dly, string tag);
        ack_dly = dly;
        s0 = n_sent;
        d0 = n_done;
        go(c, w);
        wait_idle(6 * N);
        tick();
        check({tag, "_bytes"}, n_sent - s0, N);
        check({tag, "_done"}, n_done - d0, 1);
        check({tag, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ch_sel = 3'd0; waddr = 9'd0;
        tick(3);
        check("rst_raddr", raddr, 0);
        check("rst_resp", resp, 0);
        check("rst_send_resp", send_resp, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // latency: start at edge 0, send_resp in cycle 3, immediate ack -> next at cycle 6
        ack_dly = 0;
        s0 = n_sent;
        d0 = n_done;
        go(3, 0);
        check("lat_c1_busy", busy, 1);
        check("lat_c1_send", send_resp, 0);
        tick();
        check("lat_c2_send", send_resp, 0);
        tick();
        check("lat_c3_send", send_resp, 1);
        tick();
        check("lat_c4_send", send_resp, 0);
        tick();
        check("lat_c5_send", send_resp, 0);
        tick();
        check("lat_c6_send", send_resp, 1);
        wait_idle(6 * N);
        tick();
        check("lat_bytes", n_sent - s0, N);
        check("lat_done", n_done - d0, 1);

        full_dump(3, 0, 2, "ch3_w0");

        max_a = '0;
        full_dump(1, 383, 1, "ch1_wrap");
        check("raddr_max", max_a, 383);

        // invalid channel answered with a single NAK byte
        ack_dly = 1;
        s0 = n_sent;
        d0 = n_done;
        ra = raddr;
        q.push_back('{8'hEE, ra});
        go(6, 17);
        check("nak_busy", busy, 1);
        check("nak_send", send_resp, 1);
        wait_idle(10);
        tick(2);
        check("nak_bytes", n_sent - s0, 1);
        check("nak_no_done", n_done - d0, 0);
        check("nak_raddr", raddr, ra);
        check("nak_queue_empty", q.size(), 0);

        // abort in IDLE beats start
        s0 = n_sent;
        ch_sel = 3'd2;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        tick(4);
        check("idle_abort_bytes", n_sent - s0, 0);

        // abort after byte 10
        ack_dly = 2;
        s0 = n_sent;
        d0 = n_done;
        go(2, 100);
        wait_bytes(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_send", send_resp, 0);
        q.delete();
        tick(20);
        check("abort_bytes", n_sent - s0, 10);
        check("abort_no_done", n_done - d0, 0);
        full_dump(4, 5, 0, "after_abort");

        // reset after byte 10
        ack_dly = 2;
        s0 = n_sent;
        d0 = n_done;
        go(5, 250);
        wait_bytes(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_send", send_resp, 0);
        check("midrst_raddr", raddr, 0);
        check("midrst_resp", resp, 0);
        q.delete();
        tick(20);
        check("midrst_bytes", n_sent - s0, 10);
        check("midrst_no_done", n_done - d0, 0);
        full_dump(3, 200, 1, "after_rst");

        // start and ch_sel/waddr changes while busy are ignored
        ack_dly = 1;
        s0 = n_sent;
        d0 = n_done;
        go(2, 7);
        wait_bytes(5);
        ch_sel = 3'd5;
        waddr = 9'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(6 * N);
        tick();
        check("busy_start_bytes", n_sent - s0, N);
        check("busy_start_done", n_done - d0, 1);
        check("busy_start_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
